ps2_digit_entry: RTL and testbench

//   PS/2 keyboard front end for the memorization game: receives PS/2 frames, decodes

---
 rtl/ps2_digit_entry.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_digit_entry.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_digit_entry.sv
// PS/2 keyboard front end: receives frames, decodes 0-9 / Backspace / Enter make codes, builds a 4-digit BCD guess.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
`timescale 1ns/1ps
module ps2_digit_entry #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PS2Clk,
  input  logic        PS2Data,
  output logic [15:0] userInt,
  output logic        ready
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_NORMAL, DEC_BREAK, DEC_EXT} dec_state_t;

  logic          ps2_clk_s1_q, ps2_clk_s1_d, ps2_clk_s2_q, ps2_clk_s2_d;
  logic          ps2_dat_s1_q, ps2_dat_s1_d, ps2_dat_s2_q, ps2_dat_s2_d;
  logic          filt_clk_q, filt_clk_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  rx_state_t     rx_state_q, rx_state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic          parity_ok;

  dec_state_t    dec_state_q, dec_state_d;
  logic [15:0]   user_int_q, user_int_d;
  logic          ready_q, ready_d;
  logic [2:0]    count_q, count_d;
  logic          digit_hit;
  logic [3:0]    digit_val;

`ifdef PS2_PARITY_CHECK_EN
  logic          parity_q, parity_d;
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Synchronizers and PS2Clk glitch filter
  always_comb begin
    ps2_clk_s1_d = PS2Clk;
    ps2_clk_s2_d = ps2_clk_s1_q;
    ps2_dat_s1_d = PS2Data;
    ps2_dat_s2_d = ps2_dat_s1_q;
    filt_clk_d   = filt_clk_q;
    filt_cnt_d   = '0;
    if (ps2_clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_MAX) filt_clk_d = ps2_clk_s2_q;
      else                        filt_cnt_d = filt_cnt_q + 1'b1;
    end
    filt_prev_d = filt_clk_q;
    fall        = filt_prev_q & ~filt_clk_q;
  end

  // Frame receiver
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d     = parity_q;
`endif
    if (rx_state_q == RX_IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d   = '0;
      rx_state_d = RX_IDLE;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!ps2_dat_s2_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {ps2_dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = ps2_dat_s2_q;
`endif
          rx_state_d = RX_STOP;
        end
        default: begin
          rx_state_d   = RX_IDLE;
          byte_valid_d = ps2_dat_s2_q & parity_ok;
        end
      endcase
    end
  end

  always_comb begin
    digit_hit = 1'b1;
    case (shift_q)
      8'h45:   digit_val = 4'd0;
      8'h16:   digit_val = 4'd1;
      8'h1E:   digit_val = 4'd2;
      8'h26:   digit_val = 4'd3;
      8'h25:   digit_val = 4'd4;
      8'h2E:   digit_val = 4'd5;
      8'h36:   digit_val = 4'd6;
      8'h3D:   digit_val = 4'd7;
      8'h3E:   digit_val = 4'd8;
      8'h46:   digit_val = 4'd9;
      default: begin
        digit_val = 4'd0;
        digit_hit = 1'b0;
      end
    endcase
  end

  // Scan-code decoder; once ready is set everything is frozen until reset
  always_comb begin
    dec_state_d = dec_state_q;
    user_int_d  = user_int_q;
    ready_d     = ready_q;
    count_d     = count_q;
    if (byte_valid_q && !ready_q) begin
      case (dec_state_q)
        DEC_NORMAL: begin
          if (shift_q == 8'hF0) begin
            dec_state_d = DEC_BREAK;
          end else if (shift_q == 8'hE0) begin
            dec_state_d = DEC_EXT;
          end else if (digit_hit) begin
            if (count_q < 3'd4) begin
              user_int_d = {user_int_q[11:0], digit_val};
              count_d    = count_q + 1'b1;
            end
          end else if (shift_q == 8'h66) begin
            if (count_q != 3'd0) begin
              user_int_d = {4'h0, user_int_q[15:4]};
              count_d    = count_q - 1'b1;
            end
          end else if (shift_q == 8'h5A) begin
            if (count_q == 3'd4) ready_d = 1'b1;
          end
        end
        DEC_EXT:  dec_state_d = (shift_q == 8'hF0) ? DEC_BREAK : DEC_NORMAL;
        default:  dec_state_d = DEC_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_s1_q <= 1'b1;
      ps2_clk_s2_q <= 1'b1;
      ps2_dat_s1_q <= 1'b1;
      ps2_dat_s2_q <= 1'b1;
      filt_clk_q   <= 1'b1;
      filt_prev_q  <= 1'b1;
      filt_cnt_q   <= '0;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
      dec_state_q  <= DEC_NORMAL;
      user_int_q   <= '0;
      ready_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      ps2_clk_s1_q <= ps2_clk_s1_d;
      ps2_clk_s2_q <= ps2_clk_s2_d;
      ps2_dat_s1_q <= ps2_dat_s1_d;
      ps2_dat_s2_q <= ps2_dat_s2_d;
      filt_clk_q   <= filt_clk_d;
      filt_prev_q  <= filt_prev_d;
      filt_cnt_q   <= filt_cnt_d;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
      dec_state_q  <= dec_state_d;
      user_int_q   <= user_int_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
    end
  end

  assign userInt = user_int_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed bench for ps2_digit_entry: drives PS/2 frames bit by bit and checks the assembled guess.
`timescale 1ns/1ps
module tb_ps2_digit_entry;

  localparam int TO_CYC = 300;
  localparam int HALF   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PS2Clk = 1'b1;
  logic        PS2Data = 1'b1;
  logic [15:0] userInt;
  logic        ready;

  int checks = 0;
  int errors = 0;

  ps2_digit_entry #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .userInt(userInt), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    @(negedge clk) PS2Data = b;
    repeat (HALF) @(negedge clk);
    PS2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    PS2Clk = 1'b1;
  endtask

  // Full frame; chk_lat checks ready timing around the stop-bit edge
  task automatic send_frame(input logic [7:0] code, input logic stop, input logic flip_par,
                            input logic chk_lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(flip_par ? ^code : ~^code);
    if (chk_lat) begin
      @(negedge clk) PS2Data = stop;
      repeat (HALF) @(negedge clk);
      PS2Clk = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL enter_latency_early: ready=%b expected 0", ready);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL enter_latency_2clk: ready=%b expected 1", ready);
      end
      repeat (HALF) @(negedge clk);
      PS2Clk = 1'b1;
    end else begin
      send_bit(stop);
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_frame(code, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [7:0] code);
    send_byte(code);
    send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) send_bit(code[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    PS2Clk = 1'b1;
    PS2Data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (userInt !== 16'h0000 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: userInt=%h ready=%b expected 0000/0", userInt, ready);
    end
  endtask

  task automatic test_entry();
    logic [7:0]  keys [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
    logic [15:0] exp  [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(keys[i]);
      checks++;
      if (userInt !== exp[i] || ready !== 1'b0) begin
        errors++;
        $display("FAIL entry_key%0d: userInt=%h ready=%b expected %h/0", i, userInt, ready, exp[i]);
      end
    end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (userInt !== 16'h1234 || ready !== 1'b1) begin
      errors++;
      $display("FAIL entry_commit: userInt=%h ready=%b expected 1234/1", userInt, ready);
    end
  endtask

  task automatic test_backspace();
    logic [7:0]  keys [4] = '{8'h3D, 8'h3E, 8'h66, 8'h46};
    logic [15:0] exp  [4] = '{16'h0007, 16'h0078, 16'h0007, 16'h0079};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(keys[i]);
      checks++;
      if (userInt !== exp[i] || ready !== 1'b0) begin
        errors++;
        $display("FAIL backspace_step%0d: userInt=%h ready=%b expected %h/0", i, userInt, ready, exp[i]);
      end
    end
    do_reset();
    press(8'h66);
    press(8'h16);
    checks++;
    if (userInt !== 16'h0001) begin
      errors++;
      $display("FAIL backspace_empty: userInt=%h expected 0001", userInt);
    end
  endtask

  task automatic test_overflow_lock();
    logic [7:0] keys [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 5; i++) press(keys[i]);
    checks++;
    if (userInt !== 16'h1234) begin
      errors++;
      $display("FAIL overflow_fifth: userInt=%h expected 1234", userInt);
    end
    press(8'h5A);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_commit: ready=%b expected 1", ready);
    end
    press(8'h66);
    press(8'h36);
    checks++;
    if (userInt !== 16'h1234 || ready !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold: userInt=%h ready=%b expected 1234/1", userInt, ready);
    end
  endtask

  task automatic test_enter_rules();
    do_reset();
    press(8'h16);
    press(8'h1E);
    press(8'h5A);
    checks++;
    if (userInt !== 16'h0012 || ready !== 1'b0) begin
      errors++;
      $display("FAIL enter_short: userInt=%h ready=%b expected 0012/0", userInt, ready);
    end
    press(8'h26);
    press(8'h25);
    send_byte(8'hE0);
    send_byte(8'h5A);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (userInt !== 16'h1234 || ready !== 1'b0) begin
      errors++;
      $display("FAIL enter_extended: userInt=%h ready=%b expected 1234/0", userInt, ready);
    end
    press(8'h5A);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL enter_after_ext: ready=%b expected 1", ready);
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    checks++;
    if (userInt !== 16'h0000) begin
      errors++;
      $display("FAIL framing_drop: userInt=%h expected 0000", userInt);
    end
    press(8'h16);
    checks++;
    if (userInt !== 16'h0001) begin
      errors++;
      $display("FAIL framing_recover: userInt=%h expected 0001", userInt);
    end
    do_reset();
    send_partial(8'h16, 5);
    repeat (TO_CYC + 50) @(negedge clk);
    press(8'h45);
    checks++;
    if (userInt !== 16'h0000 || ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_digit0: userInt=%h ready=%b expected 0000/0", userInt, ready);
    end
    press(8'h16);
    press(8'h1E);
    press(8'h26);
    press(8'h5A);
    checks++;
    if (userInt !== 16'h0123 || ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_count: userInt=%h ready=%b expected 0123/1", userInt, ready);
    end
  endtask

  task automatic test_parity_reset();
    logic [15:0] exp_par;
`ifdef PS2_PARITY_CHECK_EN
    exp_par = 16'h0000;
`else
    exp_par = 16'h0001;
`endif
    do_reset();
    send_frame(8'h16, 1'b1, 1'b1, 1'b0);
    checks++;
    if (userInt !== exp_par) begin
      errors++;
      $display("FAIL parity_flip: userInt=%h expected %h", userInt, exp_par);
    end
    do_reset();
    press(8'h3D);
    press(8'h3E);
    press(8'h46);
    press(8'h16);
    press(8'h5A);
    checks++;
    if (userInt !== 16'h7891 || ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_commit: userInt=%h ready=%b expected 7891/1", userInt, ready);
    end
    send_partial(8'h1E, 4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (userInt !== 16'h0000 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: userInt=%h ready=%b expected 0000/0", userInt, ready);
    end
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    press(8'h1E);
    checks++;
    if (userInt !== 16'h0002) begin
      errors++;
      $display("FAIL reset_rx_idle: userInt=%h expected 0002", userInt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h16);
    send_byte(8'h16);
    send_byte(8'hF0);
    send_byte(8'h16);
    checks++;
    if (userInt !== 16'h0011) begin
      errors++;
      $display("FAIL typematic_repeat: userInt=%h expected 0011", userInt);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_backspace();
    test_overflow_lock();
    test_enter_rules();
    test_errors();
    test_parity_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
